// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: grants one of NUM_CLIENTS requesters ownership of a shared
// instruction FIFO read port, forwards the owner's pops and tracks the number of
// bytes popped since the grant.
// Optional feature: define ROUND_ROBIN_EN for rotating priority instead of fixed
// lowest-index priority.
module fifo_port_arbiter #(
  parameter int unsigned NUM_CLIENTS = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [NUM_CLIENTS-1:0] done,
  input  logic [NUM_CLIENTS-1:0] client_rd_en,
  input  logic                   flush,
  input  logic                   fifo_empty,
  input  logic [7:0]             fifo_rd_data,
  output logic                   fifo_rd_en,
  output logic [NUM_CLIENTS-1:0] grant,
  output logic [NUM_CLIENTS-1:0] client_empty,
  output logic [NUM_CLIENTS-1:0] client_rd_valid,
  output logic [7:0]             client_rd_data,
  output logic [7:0]             byte_count
);

  typedef enum logic [0:0] {StIdle, StOwned} state_e;

  state_e                 state_q;
  logic [NUM_CLIENTS-1:0] grant_q;
  logic [NUM_CLIENTS-1:0] rd_valid_q;
  logic [7:0]             count_q;
  logic [NUM_CLIENTS-1:0] winner;
  logic                   pop;
  logic                   new_grant;

  // Only the owner may pop; flush suppresses the pop in its own cycle.
  assign pop             = (|(client_rd_en & grant_q)) & ~fifo_empty & ~flush;
  assign new_grant       = (state_q == StIdle) & ~flush & (|req);
  assign fifo_rd_en      = pop;
  assign grant           = grant_q;
  assign client_empty    = {NUM_CLIENTS{fifo_empty}} | ~grant_q;
  assign client_rd_valid = rd_valid_q;
  assign client_rd_data  = fifo_rd_data;
  assign byte_count      = count_q;

`ifdef ROUND_ROBIN_EN
  localparam int unsigned PtrW = (NUM_CLIENTS > 2) ? $clog2(NUM_CLIENTS) : 1;

  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;

  // Search upward from the pointer with wrap; first requester found wins.
  always_comb begin
    logic            found;
    logic [PtrW-1:0] idx;
    winner = '0;
    ptr_d  = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < int'(NUM_CLIENTS); k++) begin
      idx = PtrW'((int'(ptr_q) + k) % int'(NUM_CLIENTS));
      if (!found && req[idx]) begin
        found       = 1'b1;
        winner[idx] = 1'b1;
        ptr_d       = PtrW'((int'(idx) + 1) % int'(NUM_CLIENTS));
      end
    end
  end

  // Pointer moves only on a grant; flush leaves it alone.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (new_grant) begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Isolate the lowest set request bit.
  always_comb begin
    winner = req & (~req + NUM_CLIENTS'(1));
  end
`endif

  // Ownership FSM, pop-valid pipeline and per-grant byte counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      rd_valid_q <= '0;
      count_q    <= '0;
    end else begin
      // Valid follows the popping owner even if it releases in the same cycle.
      rd_valid_q <= pop ? grant_q : '0;
      if (flush) begin
        state_q <= StIdle;
        grant_q <= '0;
        count_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (|req) begin
              state_q <= StOwned;
              grant_q <= winner;
              count_q <= '0;
            end
          end
          StOwned: begin
            if (pop && count_q != 8'hff) begin
              count_q <= count_q + 8'd1;
            end
            if ((|(done & grant_q)) || !(|(req & grant_q))) begin
              state_q <= StIdle;
              grant_q <= '0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: directed scenarios plus random traffic, checked
// against an owner/counter/queue model; pop data is tracked through a scoreboard.
module tb_fifo_port_arbiter;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req, done, client_rd_en;
  logic         flush, fifo_empty;
  logic [7:0]   fifo_rd_data;
  logic         fifo_rd_en;
  logic [N-1:0] grant, client_empty, client_rd_valid;
  logic [7:0]   client_rd_data, byte_count;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.NUM_CLIENTS(N)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req             (req),
    .done            (done),
    .client_rd_en    (client_rd_en),
    .flush           (flush),
    .fifo_empty      (fifo_empty),
    .fifo_rd_data    (fifo_rd_data),
    .fifo_rd_en      (fifo_rd_en),
    .grant           (grant),
    .client_empty    (client_empty),
    .client_rd_valid (client_rd_valid),
    .client_rd_data  (client_rd_data),
    .byte_count      (byte_count)
  );

  typedef struct {
    int         cycle;
    int         client;
    logic [7:0] data;
  } exp_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  exp_t       sb_q[$];
  logic [7:0] fifo_q[$];   // FIFO as the DUT drains it
  logic [7:0] model_q[$];  // FIFO as the model drains it
  int         owner    = -1;
  int         rr_ptr   = 0;
  int         cnt      = 0;
  bit         dut_pop  = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
    end
  endfunction

  function automatic logic [31:0] exp_grant();
    return (owner < 0) ? 32'd0 : (32'd1 << owner);
  endfunction

  function automatic int pick(logic [N-1:0] r);
`ifdef ROUND_ROBIN_EN
    for (int k = 0; k < N; k++) if (r[(rr_ptr + k) % N]) return (rr_ptr + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  // One clock of stimulus: check registered state, apply inputs, check combinational
  // outputs, then advance the model.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d, input logic [N-1:0] e,
                      input logic f, input int push_n);
    logic [7:0] b;
    bit         exp_pop;
    int         w;
    @(posedge clk);
    #1;
    cyc++;
    if (dut_pop && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    chk("grant", grant, exp_grant());
    chk("byte_count", byte_count, cnt);
    for (int i = 0; i < push_n; i++) begin
      b = 8'($urandom);
      fifo_q.push_back(b);
      model_q.push_back(b);
    end
    fifo_empty   = (fifo_q.size() == 0);
    req          = r;
    done         = d;
    client_rd_en = e;
    flush        = f;
    #1;
    exp_pop = (owner >= 0) && e[owner] && !fifo_empty && !f;
    chk("fifo_rd_en", fifo_rd_en, exp_pop);
    for (int i = 0; i < N; i++) chk("client_empty", client_empty[i], fifo_empty || owner != i);
    chk("client_rd_data", client_rd_data, fifo_rd_data);
    dut_pop = fifo_rd_en;
    if (exp_pop) begin
      b = (model_q.size() > 0) ? model_q.pop_front() : 8'h00;
      sb_q.push_back('{cyc + 1, owner, b});
      if (cnt < 255) cnt++;
    end
    if (f) begin
      owner = -1;
      cnt   = 0;
    end else if (owner >= 0) begin
      if (d[owner] || !r[owner]) owner = -1;
    end else if (r != '0) begin
      w     = pick(r);
      owner = w;
      cnt   = 0;
`ifdef ROUND_ROBIN_EN
      rr_ptr = (w + 1) % N;
`endif
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    model_q.push_back(b);
  endtask

  // Asynchronous reset in the middle of a cycle, held over one edge, then released
  // with inputs idle.
  task automatic reset_mid(input logic [N-1:0] r_during);
    @(posedge clk);
    #1;
    cyc++;
    if (dut_pop && fifo_q.size() > 0) fifo_rd_data = fifo_q.pop_front();
    reset_n = 1'b0;
    req     = r_during;
    #1;
    chk("reset_grant", grant, 0);
    chk("reset_fifo_rd_en", fifo_rd_en, 0);
    chk("reset_byte_count", byte_count, 0);
    chk("reset_rd_valid", client_rd_valid, 0);
    sb_q.delete();
    owner   = -1;
    cnt     = 0;
    rr_ptr  = 0;
    dut_pop = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    chk("reset_held_grant", grant, 0);
    chk("reset_held_fifo_rd_en", fifo_rd_en, 0);
    reset_n      = 1'b1;
    req          = '0;
    done         = '0;
    client_rd_en = '0;
    flush        = 1'b0;
  endtask

  // Monitor: every valid pulse must match the oldest expected pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) continue;
      if (client_rd_valid != '0) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rd_valid", client_rd_valid, 0);
        end else begin
          e = sb_q.pop_front();
          chk("rd_valid_cycle", cyc, e.cycle);
          chk("rd_valid_client", client_rd_valid, 32'd1 << e.client);
          chk("rd_valid_data", client_rd_data, e.data);
        end
      end else if (sb_q.size() > 0 && sb_q[0].cycle <= cyc) begin
        e = sb_q.pop_front();
        chk("missing_rd_valid", client_rd_valid, 32'd1 << e.client);
      end
    end
  end

  initial begin
    logic [N-1:0] r, d, en;
    reset_n      = 1'b0;
    req          = '0;
    done         = '0;
    client_rd_en = '0;
    flush        = 1'b0;
    fifo_empty   = 1'b1;
    fifo_rd_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("por_grant", grant, 0);
    chk("por_rd_valid", client_rd_valid, 0);
    reset_n = 1'b1;
    step('0, '0, '0, 1'b0, 0);

    // Simultaneous request: client 1 wins, client 2 waits for done.
    step(3'b110, '0, '0, 1'b0, 0);
    step(3'b110, 3'b100, '0, 1'b0, 0);
    step(3'b110, '0, 3'b100, 1'b0, 1);
    step(3'b110, 3'b010, '0, 1'b0, 0);
    step(3'b110, '0, '0, 1'b0, 0);
    step(3'b100, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);

    // Owner 1 pops three known bytes; FIFO drained before.
    while (fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
    end
    model_q.delete();
    step(3'b010, '0, '0, 1'b0, 0);
    push_byte(8'h8B);
    push_byte(8'h46);
    push_byte(8'hFC);
    step(3'b010, '0, 3'b010, 1'b0, 0);
    step(3'b010, '0, 3'b010, 1'b0, 0);
    step(3'b010, '0, 3'b010, 1'b0, 0);
    // FIFO now empty: further pop requests must be ignored.
    step(3'b010, '0, 3'b010, 1'b0, 0);
    step(3'b010, '0, 3'b010, 1'b0, 0);
    // Pop together with done still yields a valid after grant drops.
    step(3'b010, 3'b010, 3'b010, 1'b0, 1);
    step('0, '0, '0, 1'b0, 0);

    // Flush while owner 0 pops.
    step(3'b001, '0, '0, 1'b0, 2);
    step(3'b001, '0, 3'b001, 1'b0, 0);
    step(3'b001, '0, 3'b001, 1'b1, 0);
    step(3'b001, '0, 3'b001, 1'b0, 1);
    step('0, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);

    // Rotation with all requesting and done after each grant.
    for (int i = 0; i < 4; i++) begin
      step(3'b111, '0, '0, 1'b0, 0);
      step(3'b111, 3'b111, '0, 1'b0, 0);
    end
    step('0, '0, '0, 1'b0, 0);

    // Long ownership to reach byte_count saturation.
    step(3'b001, '0, '0, 1'b0, 1);
    for (int i = 0; i < 300; i++) step(3'b001, '0, 3'b001, 1'b0, 1);
    step('0, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);

    // Random traffic.
    r = '0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) r = N'($urandom);
      d  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      en = N'($urandom);
      step(r, d, en, ($urandom_range(0, 40) == 0), int'($urandom_range(0, 1)));
    end
    step('0, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);

    // Reset while owner 2 pops, then a fresh request from client 2.
    step(3'b100, '0, '0, 1'b0, 3);
    step(3'b100, '0, 3'b100, 1'b0, 1);
    step(3'b100, '0, 3'b100, 1'b0, 1);
    reset_mid(3'b100);
    step(3'b100, '0, '0, 1'b0, 0);
    step(3'b100, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);
    step('0, '0, '0, 1'b0, 0);

    @(negedge clk);
    @(negedge clk);
    if (sb_q.size() != 0) chk("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
